// File: rtl/if_stage_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage:
// default PC parameters, the redirect-select helpers and the queue entry layout.
package if_pkg;

  // Default sequential increment and reset fetch address.
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Widest PC the redirect helpers carry; callers zero-extend into it and
  // truncate the result back to their own PC width.
  localparam int unsigned PC_MAX_W = 64;

  // Layout of one queue entry in the default 32/32 configuration.
  // The queue stores {pc, inst} with pc in the upper bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  // A redirect is requested by either a taken EXE branch or an ID jump.
  function automatic logic redirect_req(input logic branch, input logic jump);
    return branch | jump;
  endfunction

  // The older instruction (the branch in EXE) has priority over the jump in ID.
  function automatic logic [PC_MAX_W-1:0] redirect_target(
    input logic                branch,
    input logic [PC_MAX_W-1:0] bpc,
    input logic [PC_MAX_W-1:0] jpc
  );
    return branch ? bpc : jpc;
  endfunction

endpackage

// File: rtl/if_stage_prefetch_inst_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// Flush and reset both empty the queue at the next rising edge; a flush
// takes priority over a push or pop requested in the same cycle.
module inst_queue
  import if_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // A push into a full queue is only accepted when a pop frees the slot
  // in the same cycle; a pop from an empty queue is ignored.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Entry storage: written on push only, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a decoupled prefetch queue.
// Issues sequential requests to a 1-cycle synchronous instruction memory,
// buffers {PC, Inst} pairs and presents the oldest one to ID.
//
// Handshake: IF_valid marks a meaningful head. ID consumes the head in any
// cycle where IF_valid=1 and stall=0, unless a redirect (Branch or Jump) is
// asserted in that cycle, in which case the head is discarded with the rest
// of the queue. When IF_valid=0, IF_PC/IF_Inst read 0 and stall is ignored.
//
// Timing: a request in cycle N returns data in N+1, which is written into the
// queue at the end of N+1 and is visible at the outputs in N+2.
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter  int unsigned       PC_W     = 32,
  parameter  int unsigned       INST_W   = 32,
  parameter  logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF),
  parameter  int unsigned       PC_STEP  = PC_STEP_DEF,
  parameter  int unsigned       QDEPTH   = 4,
  localparam int unsigned       CNT_W    = $clog2(QDEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Jump,
  input  logic [PC_W-1:0]   ID_jpc,
  input  logic              Branch,
  input  logic [PC_W-1:0]   EXE_bpc,
  input  logic              stall,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              IF_valid,
  output logic [INST_W-1:0] IF_Inst,
  output logic [PC_W-1:0]   IF_PC,
  output logic [CNT_W-1:0]  q_count
);

  localparam int unsigned ENTRY_W = PC_W + INST_W;

  // Fetch-side state.
  logic [PC_W-1:0] r_fpc;       // next address to request
  logic [PC_W-1:0] r_pc_d;      // address of the request now in flight
  logic            r_inflight;  // a response is due on imem_rdata this cycle
  logic            r_reset_d;   // Reset delayed by one cycle

  // Redirect decode.
  logic            w_redir;
  logic [PC_W-1:0] w_target;

  // Queue interface.
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_empty;
  logic               w_full;
  logic               w_valid;

  // Credit accounting.
  logic [CNT_W:0]  w_occ;
  logic            w_credit;
  logic            w_req;

  assign w_redir  = redirect_req(Branch, Jump);
  assign w_target = PC_W'(redirect_target(Branch, PC_MAX_W'(EXE_bpc), PC_MAX_W'(ID_jpc)));

  // Occupancy counts the entry still in flight so the queue can never be
  // asked to take more than QDEPTH entries. A pop in the same cycle is not
  // credited back until the following cycle.
  assign w_occ    = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_credit = (w_occ < (CNT_W + 1)'(QDEPTH)) && !w_full;

  // No request while in reset, in the first cycle after reset, or while a
  // redirect is being taken (the fetch address is about to change).
  assign w_req = !Reset && !r_reset_d && !w_redir && w_credit;

  // The response is written unless a redirect or reset kills it at this edge.
  assign w_push = r_inflight && !w_redir && !Reset;

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && !stall && !w_redir && !Reset;

  inst_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .i_clk       (CLK),
    .i_rst       (Reset),
    .i_flush     (w_redir),
    .i_push      (w_push),
    .i_push_data ({r_pc_d, imem_rdata}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // Remember whether the previous cycle was in reset.
  always_ff @(posedge CLK) begin
    r_reset_d <= Reset;
  end

  // Fetch PC, in-flight flag and the address that goes with the response.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_fpc      <= RESET_PC;
      r_pc_d     <= '0;
      r_inflight <= 1'b0;
    end else if (w_redir) begin
      r_fpc      <= w_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc_d <= r_fpc;
        r_fpc  <= r_fpc + PC_W'(PC_STEP);
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_fpc;

  assign IF_valid = w_valid;
  assign IF_PC    = w_valid ? w_head[ENTRY_W-1 -: PC_W] : '0;
  assign IF_Inst  = w_valid ? w_head[INST_W-1:0]        : '0;
  assign q_count  = w_count;

endmodule
